// File: rtl/dmem_line_responder.sv
// D-cache line responder: serializes 256-bit fills/write-backs into 8 SRAM beats; DMEM_WB_FORWARD_EN adds a write-back line buffer.
// Latency: write ready at T+9+WAIT_CYCLES, read at T+9+RD_LAT+WAIT_CYCLES (T+2+WAIT_CYCLES on a buffer hit).
// Backpressure: the cache holds mem_valid until mem_ready; the SRAM port accepts one beat per cycle without stalling.
module dmem_line_responder #(
    parameter int ADDR_WIDTH  = 28,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 256,
    parameter int RD_LAT      = 1,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] mem_wr,
    input  logic                  mem_rw,
    input  logic                  mem_valid,
    output logic [BLOCK_SIZE-1:0] mem_rd,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_en,
    output logic                  sram_we,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  busy
);
    localparam int BEATS = BLOCK_SIZE / DATA_WIDTH;
    localparam int CW    = $clog2(BEATS);
    localparam int LW    = ADDR_WIDTH - CW;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [3:0]    WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, WAIT, DONE} state_t;
    localparam state_t POST_STATE = (WAIT_CYCLES == 0) ? DONE : WAIT;

    state_t                  state, state_nxt;
    logic [LW-1:0]           addr_q;
    logic                    rw_q;
    logic [BLOCK_SIZE-1:0]   line_q;
    logic [CW-1:0]           cnt;
    logic [3:0]              wcnt;
    logic [BLOCK_SIZE-1:0]   rd_buf, rd_line_nxt;
    logic [RD_LAT-1:0]       pipe_vld;
    logic [RD_LAT-1:0][CW-1:0] pipe_idx;
    logic                    ret_vld;
    logic [CW-1:0]           ret_idx;
    logic                    fwd_hit;
    logic                    fill_from_fwd;
    logic [BLOCK_SIZE-1:0]   fwd_line;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[CW-1:0];
    assign ret_vld = pipe_vld[RD_LAT-1];
    assign ret_idx = pipe_idx[RD_LAT-1];
    assign busy    = (state != IDLE);

`ifdef DMEM_WB_FORWARD_EN
    logic          fwd_vld;
    logic [LW-1:0] fwd_addr;

    // Most recent completed write-back; replaced by every write regardless of address.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld <= 1'b0;
        end else if (state == WRITE && cnt == LAST_BEAT) begin
            fwd_vld  <= 1'b1;
            fwd_addr <= addr_q;
            fwd_line <= line_q;
        end
    end
    assign fwd_hit = fwd_vld && (fwd_addr == addr_q);
`else
    assign fwd_hit  = 1'b0;
    assign fwd_line = '0;
`endif

    always_comb begin
        state_nxt     = state;
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;
        mem_ready     = 1'b0;
        fill_from_fwd = 1'b0;
        case (state)
            IDLE: begin
                if (mem_valid) state_nxt = mem_rw ? WRITE : READ;
            end
            WRITE: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = {addr_q, cnt};
                sram_wdata = line_q[cnt*DATA_WIDTH +: DATA_WIDTH];
                if (cnt == LAST_BEAT) state_nxt = POST_STATE;
            end
            READ: begin
                if (fwd_hit) begin
                    fill_from_fwd = 1'b1;
                    state_nxt     = POST_STATE;
                end else begin
                    sram_en   = 1'b1;
                    sram_addr = {addr_q, cnt};
                    if (cnt == LAST_BEAT) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_vld && ret_idx == LAST_BEAT) state_nxt = POST_STATE;
            end
            WAIT: begin
                if (wcnt == WAIT_LAST) state_nxt = DONE;
            end
            DONE: begin
                // A cache that moved on (dropped valid or changed request) gets no pulse.
                mem_ready = mem_valid && (mem_addr[ADDR_WIDTH-1:CW] == addr_q) && (mem_rw == rw_q);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_line_nxt = rd_buf;
        rd_line_nxt[ret_idx*DATA_WIDTH +: DATA_WIDTH] = sram_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            line_q   <= '0;
            cnt      <= '0;
            wcnt     <= '0;
            pipe_vld <= '0;
            pipe_idx <= '0;
            rd_buf   <= '0;
            mem_rd   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && mem_valid) begin
                addr_q <= mem_addr[ADDR_WIDTH-1:CW];
                rw_q   <= mem_rw;
                line_q <= mem_wr;
                cnt    <= '0;
            end else if (sram_en) begin
                cnt <= cnt + 1'b1;
            end
            wcnt <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
            // Beat index rides alongside the SRAM read latency.
            pipe_vld[0] <= sram_en && !sram_we;
            pipe_idx[0] <= cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end
            if (ret_vld) begin
                rd_buf <= rd_line_nxt;
                if (ret_idx == LAST_BEAT) mem_rd <= rd_line_nxt;
            end
            if (fill_from_fwd) mem_rd <= fwd_line;
        end
    end
endmodule

// File: doc/dmem_line_responder.md
Name: dmem_line_responder

Overview:
- Memory-side responder for the data-cache line interface.
- Accepts 256-bit line write-backs and line fills from the D-cache controller. Each transfer is serialized as 8 beats over a 32-bit synchronous SRAM/backing-store port.
- Returns a one-cycle mem_ready with the assembled line.
- Sits between the D-cache and the main data memory in the 50 MHz top level.

Parameters:
- ADDR_WIDTH, 28: word address width of both ports.
- DATA_WIDTH, 32: SRAM beat width.
- BLOCK_SIZE, 256: line width; beats = BLOCK_SIZE/DATA_WIDTH = 8.
- RD_LAT, 1: SRAM read latency in cycles, legal range 1..4.
- WAIT_CYCLES, 0: extra idle cycles inserted before mem_ready, used for DRAM-timing modelling, legal range 0..15.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- mem_addr, in, 28: line word address; bits [2:0] are ignored.
- mem_wr, in, 256: write-back line; word j = mem_wr[j*32+:32].
- mem_rw, in, 1: 1 = write line, 0 = read line.
- mem_valid, in, 1: request valid, held by the cache until mem_ready.
- mem_rd, out, 256: fill line, registered.
- mem_ready, out, 1: one-cycle completion pulse.
- sram_addr, out, 28: beat word address.
- sram_wdata, out, 32: beat write data.
- sram_en, out, 1: beat strobe.
- sram_we, out, 1: beat write enable.
- sram_rdata, in, 32: read data, valid RD_LAT cycles after an sram_en with sram_we=0.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; mem_ready=0; mem_rd=0; sram_en=0; sram_we=0; sram_addr=0; sram_wdata=0; busy=0.
- Reset mid-transfer aborts immediately. No further sram_en is issued and no mem_ready follows. Beats already written stay written.
- FSM states: IDLE, WRITE, READ, DRAIN, WAIT, DONE.
- IDLE: on mem_valid=1, latch addr_q={mem_addr[27:3],3'b0}, rw_q=mem_rw and line_q=mem_wr. Clear beat counter cnt (3 bits). Go to WRITE if mem_rw, else READ.
- WRITE: each cycle drive sram_en=1, sram_we=1, sram_addr={addr_q[27:3],cnt}, sram_wdata=line_q[cnt*32+:32]. Increment cnt. After beat 7, go to WAIT (or DONE if WAIT_CYCLES=0).
- READ: each cycle drive sram_en=1, sram_we=0, sram_addr as in WRITE. Increment cnt. After beat 7, go to DRAIN.
- Read return path: a RD_LAT-deep shift register carries the beat index. Returned sram_rdata is written into mem_rd[idx*32+:32].
- DRAIN: wait until the last beat has returned (RD_LAT cycles after issue of beat 7), then go to WAIT or DONE.
- WAIT: count WAIT_CYCLES cycles, then go to DONE.
- DONE: one cycle, then IDLE.
  - mem_ready=1 only if mem_valid=1, mem_addr[27:3]==addr_q[27:3] and mem_rw==rw_q. Otherwise the request was abandoned by the cache: no pulse, go to IDLE.
  - Work already done is not undone.
- mem_rd holds the last completed fill until the next read's last beat overwrites it. Write transactions never modify mem_rd.
- Latency, request accepted at cycle T:
  - write: beats at T+1..T+8; mem_ready at T+9+WAIT_CYCLES.
  - read: issue at T+1..T+8; mem_ready at T+9+RD_LAT+WAIT_CYCLES.
- Back-to-back requests: IDLE samples in the cycle after DONE. A write-back immediately followed by a fill with mem_valid continuously high is accepted with a one-cycle gap.
- mem_valid changes outside IDLE and DONE are ignored.
- cnt wraps 7→0 only on state exit.

Optional Feature:
- Macro: DMEM_WB_FORWARD_EN.
- When defined:
  - A one-entry line buffer holds the most recent completed write (address plus 256-bit data), with a valid bit. The valid bit clears on reset.
  - A read whose addr_q matches the buffer skips READ/DRAIN. mem_rd is loaded from the buffer and the FSM goes to WAIT/DONE, so mem_ready arrives at T+2+WAIT_CYCLES.
  - No sram_en is issued for that read.
  - A write to the same address updates the buffer.
- When undefined: no buffer; every read accesses the SRAM.

Test Plan:
1. Write line: mem_addr=28'h0000123, mem_wr word j = 32'hA000_0000+j, rw=1, WAIT_CYCLES=0 -> eight sram writes at addresses 28'h0000120..28'h0000127 with data A0000000..A0000007; mem_ready at T+9, width 1 cycle.
2. Read fill, RD_LAT=2, SRAM preloaded word j = 32'hB000_000j at 28'h0000040.. -> mem_rd = {B0000007,...,B0000000}; mem_ready at T+11; mem_rd stable afterwards.
3. Write-back then fill with mem_valid held high, rw/addr switched in the cycle after mem_ready -> second request accepted one cycle after DONE; both complete; no spurious second mem_ready.
4. Abandon: drop mem_valid during READ beat 3 -> remaining beats still issue; mem_ready stays 0; IDLE reached and a new request is accepted normally.
5. Reset asserted during WRITE beat 4 -> next cycle sram_en=0, busy=0, mem_ready=0; beats 5..7 are never written.
6. With DMEM_WB_FORWARD_EN: write line to 28'h0000200, then read 28'h0000200 -> mem_ready at T+2; no sram_en during the read; mem_rd equals the written line. Then read 28'h0000208 -> normal SRAM path.
